// File: rtl/seq_signed_mult.sv
// Sequential signed shift-add multiplier: captures two's-complement operands on
// start, accumulates magnitudes over WIDTH cycles, then applies the sign.
module seq_signed_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t               state, state_next;
  logic [2*WIDTH-1:0]   mcand, mcand_next;
  logic [WIDTH-1:0]     mplier, mplier_next;
  logic [2*WIDTH-1:0]   acc, acc_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 neg, neg_next;
  logic [2*WIDTH-1:0]   product_next;
  logic                 busy_next, done_next;
  logic [WIDTH-1:0]     mag_a, mag_b;

  // The most negative operand negates to itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is needed.
  assign mag_a = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
  assign mag_b = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      neg     <= neg_next;
      product <= product_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    mcand_next   = mcand;
    mplier_next  = mplier;
    acc_next     = acc;
    cnt_next     = cnt;
    neg_next     = neg;
    product_next = product;
    busy_next    = busy;
    done_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          mcand_next  = {{WIDTH{1'b0}}, mag_a};
          mplier_next = mag_b;
          neg_next    = a[WIDTH-1] ^ b[WIDTH-1];
          acc_next    = '0;
          cnt_next    = '0;
          busy_next   = 1'b1;
          state_next  = CALC;
        end
      end

      CALC: begin
        if (mplier[0]) begin
          acc_next = acc + mcand;
        end
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        cnt_next    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_next = SIGN;
        end
      end

      SIGN: begin
        // Negating a zero accumulator yields zero again, so no -0 can appear.
        product_next = neg ? (~acc) + (2*WIDTH)'(1) : acc;
        done_next    = 1'b1;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_signed_mult.sv
// Self-checking bench for seq_signed_mult: directed vector table, random
// operands against an integer-multiply reference, and start/reset corner cases.
module tb_seq_signed_mult;

  localparam int WIDTH = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] expected;
  } vector_t;

  vector_t vectors[8];

  seq_signed_mult #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference: plain signed integer multiplication truncated to the product width.
  function automatic logic [2*WIDTH-1:0] refProduct(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return (2*WIDTH)'(sx * sy);
  endfunction

  // Issues one start pulse with the given operands and checks the full
  // transaction: busy length, latency, result, done/busy exclusivity, hold.
  task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                               input logic [2*WIDTH-1:0] expected, input string name);
    int busyCount;
    int latency;
    logic busyAtDone;
    logic [2*WIDTH-1:0] result;
    busyCount = 0;
    latency = 0;
    busyAtDone = 1'b1;
    @(negedge clk);
    a = opA;
    b = opB;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy) busyCount++;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (done) begin
        latency = cyc;
        busyAtDone = busy;
        break;
      end
      if (busy) busyCount++;
    end
    if (latency == 0) begin
      checkOutput({name, " done timeout"}, 32'(latency), 32'(WIDTH + 1));
    end else begin
      result = product;
      checkOutput({name, " product"}, 32'(result), 32'(expected));
      checkOutput({name, " latency"}, 32'(latency), 32'(WIDTH + 1));
      checkOutput({name, " busy cycles"}, 32'(busyCount), 32'(WIDTH + 1));
      checkOutput({name, " busy at done"}, 32'(busyAtDone), 32'(0));
      @(negedge clk);
      checkOutput({name, " done pulse width"}, 32'(done), 32'(0));
      checkOutput({name, " product hold"}, 32'(product), 32'(expected));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int doneCount;
    int busyAfterDone;
    logic sawDone;

    vectors[0] = '{8'h05, 8'h03, 16'h000F};
    vectors[1] = '{8'hFF, 8'h7F, 16'hFF81};
    vectors[2] = '{8'h80, 8'h80, 16'h4000};
    vectors[3] = '{8'h80, 8'h7F, 16'hC080};
    vectors[4] = '{8'h00, 8'hF9, 16'h0000};
    vectors[5] = '{8'h7F, 8'h7F, 16'h3F01};
    vectors[6] = '{8'hFF, 8'hFF, 16'h0001};
    vectors[7] = '{8'h01, 8'h80, 16'hFF80};

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset product", 32'(product), 32'(0));
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset done", 32'(done), 32'(0));

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, vectors[i].expected, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      applyStimulus(ra, rb, refProduct(ra, rb), $sformatf("rand%0d", i));
    end

    // Extra starts during CALC and on the SIGN edge, operands changed mid-run.
    $display("[TB] ignored-start sequence");
    doneCount = 0;
    busyAfterDone = 0;
    sawDone = 1'b0;
    @(negedge clk);
    a = 8'hFD;
    b = 8'h07;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        doneCount++;
        sawDone = 1'b1;
        checkOutput("ignored-start product", 32'(product), 32'(refProduct(8'hFD, 8'h07)));
      end else if (sawDone && busy) begin
        busyAfterDone++;
      end
      if (k == 1) begin
        a = 8'h11;
        b = 8'h22;
      end
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (k == WIDTH) start = 1'b1;
      if (k == WIDTH + 1) start = 1'b0;
    end
    checkOutput("ignored-start done count", 32'(doneCount), 32'(1));
    checkOutput("ignored-start busy after done", 32'(busyAfterDone), 32'(0));

    // Reset asserted partway through a calculation.
    $display("[TB] reset mid-operation sequence");
    doneCount = 0;
    @(negedge clk);
    a = 8'h09;
    b = 8'h09;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("mid-reset product", 32'(product), 32'(0));
    checkOutput("mid-reset busy", 32'(busy), 32'(0));
    checkOutput("mid-reset done", 32'(done), 32'(0));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkOutput("mid-reset stays idle", 32'(doneCount), 32'(0));
    applyStimulus(8'h09, 8'h09, 16'h0051, "after-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_signed_mult.md
Name: seq_signed_mult

Overview:
- Sequential signed WIDTH x WIDTH shift-add multiplier core.
- Sits directly downstream of the pushbutton detection chain. Its `start` input is the one-cycle pulse produced by that chain.
- Captures two's-complement operands on `start` and multiplies magnitudes over WIDTH cycles. It then applies the sign and presents a 2*WIDTH-bit signed product with a one-cycle `done` pulse.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
start  input  1  single-cycle start pulse from the pushbutton detector
a  input  WIDTH  multiplicand, two's complement
b  input  WIDTH  multiplier, two's complement
product  output  2*WIDTH  signed result, registered; holds until the next completion
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when product updates

Behaviour:
- Reset (rst=0 at rising edge): state=IDLE; product=0, busy=0, done=0, all internal registers 0. Reset has priority over every other input, including mid-operation; a partial result is discarded and product is cleared to 0.
- States: IDLE, CALC, SIGN.
- IDLE, start=1 at edge:
  - Capture mag_a=|a| and mag_b=|b| as WIDTH-bit unsigned values. The most negative value maps to 2^(WIDTH-1), e.g. -128 -> 0x80, with no overflow.
  - Capture neg = a[WIDTH-1] ^ b[WIDTH-1]. Clear acc (2*WIDTH bits) and cnt.
  - Move to CALC; busy=1.
- IDLE, start=0: hold all state; done=0.
- CALC, each edge:
  - If mplier[0]=1, acc <= acc + mcand. mcand is zero-extended to 2*WIDTH bits and left-shifted once per cycle.
  - mplier shifts right by 1; cnt increments.
  - After exactly WIDTH CALC cycles (cnt reaches WIDTH-1 on the final one), move to SIGN.
- SIGN, one edge:
  - product <= neg ? (~acc + 1) : acc. A zero result is always +0, i.e. 0 * negative = 0x0000.
  - done=1 for this single cycle; busy=0; move to IDLE.
- Latency: start accepted at edge E0. CALC edges are E1..E_WIDTH. product and done are valid after edge E(WIDTH+1), so WIDTH+1 cycles (9 for WIDTH=8).
- Timing of start relative to state:
  - start while busy (CALC or SIGN) is ignored, not queued.
  - A start pulse coinciding with the SIGN edge is lost.
  - The earliest accepted restart is the edge after done.
- Operands are sampled only at acceptance. Changes to a/b during CALC have no effect.
- done is never asserted in the same cycle as busy=1.
- product is stable between completions and is unaffected by IDLE.
- Width rule: the magnitude product is at most 2^(2*WIDTH-2), which fits the signed 2*WIDTH range, so the result never overflows.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> product=0x0000, busy=0, done=0.
- Positive operands: a=5, b=3, start pulse -> busy=1 for 9 cycles, then done=1 for 1 cycle with product=0x000F; product holds afterwards.
- Mixed signs: a=-1 (0xFF), b=127 (0x7F) -> product=0xFF81 (-127). Then a=-128, b=-128 -> product=0x4000 (16384). Then a=-128, b=127 -> product=0xC080 (-16256).
- Zero: a=0, b=-7 -> product=0x0000; no negative zero.
- Ignored start: start at E0, extra start pulses at E3 and at the SIGN edge, a/b changed at E2 -> exactly one done; product is computed from the E0 operands; busy stays 0 after done.
- Reset mid-op: start with a=9, b=9, assert rst=0 at E4 -> product=0, busy=0, done never pulses. A new start then produces 0x0051 after 9 cycles.
